// File: rtl/fifo_merge_rr_if.sv
// ---------------------------------------------------------------------------
// fifo_merge_rr_if
// Bundle of the source-side and sink-side handshake signals of the
// round-robin FIFO merger.
//   SRC_EMPTY  : per-source empty flag (low = SRC_DATA slice valid, FWFT)
//   SRC_DATA   : concatenated source words, source i at [i*DSIZE +: DSIZE]
//   SRC_READ   : one-hot pop strobe back to the granted source
//   OUT_READ   : downstream pop of the current OUT_DATA
//   OUT_EMPTY  : output buffer holds no word
//   OUT_DATA   : head word of the output buffer
//   GRANT      : registered one-hot grant, zero when idle
//   READ_ERROR : sticky flag, downstream popped an empty buffer
// Modports: master = sources + downstream reader, slave = the merger.
// ---------------------------------------------------------------------------
interface fifo_merge_rr_if #(
  parameter int N_SRC = 5,
  parameter int DSIZE = 32
);
  logic [N_SRC-1:0]       SRC_EMPTY;
  logic [N_SRC*DSIZE-1:0] SRC_DATA;
  logic [N_SRC-1:0]       SRC_READ;
  logic                   OUT_READ;
  logic                   OUT_EMPTY;
  logic [DSIZE-1:0]       OUT_DATA;
  logic [N_SRC-1:0]       GRANT;
  logic                   READ_ERROR;

  modport master (
    output SRC_EMPTY, SRC_DATA, OUT_READ,
    input  SRC_READ, OUT_EMPTY, OUT_DATA, GRANT, READ_ERROR
  );

  modport slave (
    input  SRC_EMPTY, SRC_DATA, OUT_READ,
    output SRC_READ, OUT_EMPTY, OUT_DATA, GRANT, READ_ERROR
  );
endinterface

// File: rtl/fifo_merge_rr.sv
// ---------------------------------------------------------------------------
// fifo_merge_rr
// Round-robin merger of N_SRC first-word-fall-through sources into one word
// stream. A grant is held for at most MAX_BURST words (or until the source
// runs empty), then the search pointer moves past the granted source. Words
// pass through a registered 2-entry output buffer, so OUT_DATA/OUT_EMPTY
// come straight from flops.
// Ports:
//   BUS_CLK  : single clock
//   BUS_RST  : synchronous active-high reset
//   bus      : fifo_merge_rr_if.slave (sources, output stream, status)
// Parameters: N_SRC sources, DSIZE word width, MAX_BURST 1..255.
// ---------------------------------------------------------------------------
module fifo_merge_rr #(
  parameter int N_SRC     = 5,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST,
  fifo_merge_rr_if.slave  bus
);

  localparam int          IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned NS = N_SRC;

  typedef enum logic {IDLE, BURST} state_t;

  // (base + step) mod N_SRC, for base < N_SRC and step <= N_SRC
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input int unsigned  step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= NS) sum = sum - NS;
    return IW'(sum);
  endfunction

  state_t           state_reg;
  logic [IW-1:0]    g_reg;
  logic [IW-1:0]    ptr_reg;
  logic [7:0]       bcnt_reg;
  logic [N_SRC-1:0] grant_reg;

  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [DSIZE-1:0] head_reg;
  logic [DSIZE-1:0] tail_reg;
  logic             empty_reg;
  logic             err_reg;

  logic [DSIZE-1:0] src_word [N_SRC];
  logic [IW-1:0]    cand [N_SRC];
  logic [N_SRC-1:0] req_rot;
  logic [N_SRC-1:0] pick_onehot;
  logic [IW-1:0]    pick;
  logic             any_req;

  logic             src_empty_g;
  logic             room;
  logic             xfer;
  logic             pop;
  logic             last_word;

  // Unpack the source bus and build the request vector rotated so that
  // position 0 is the source the pointer currently designates.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src_word[gi]    = bus.SRC_DATA[gi*DSIZE +: DSIZE];
    assign cand[gi]        = wrap_add(ptr_reg, gi);
    assign req_rot[gi]     = ~bus.SRC_EMPTY[cand[gi]];
    assign pick_onehot[gi] = (pick == IW'(gi));
    assign bus.SRC_READ[gi] = xfer & (g_reg == IW'(gi));
  end

  // First requester in search order; descending loop so the lowest
  // rotated position wins.
  always_comb begin
    pick    = ptr_reg;
    any_req = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick    = cand[k];
        any_req = 1'b1;
      end
    end
  end

  assign src_empty_g = bus.SRC_EMPTY[g_reg];
  // A full buffer still accepts a word when the head leaves this cycle.
  assign room        = (count_reg != 2'd2) | bus.OUT_READ;
  // Gated by reset so nothing is popped from a source in the reset cycle.
  assign xfer        = ~BUS_RST & (state_reg == BURST) & ~src_empty_g & room;
  assign pop         = bus.OUT_READ & ~empty_reg;
  assign last_word   = ({1'b0, bcnt_reg} + 9'd1) == 9'(MAX_BURST);

  // Arbitration FSM
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      ptr_reg   <= '0;
      bcnt_reg  <= '0;
      grant_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            g_reg     <= pick;
            grant_reg <= pick_onehot;
            bcnt_reg  <= '0;
            state_reg <= BURST;
          end else begin
            grant_reg <= '0;
          end
        end
        BURST: begin
          // Source drained, or the burst quota is used up by this word:
          // release and move the search start past this source.
          if (src_empty_g || (xfer && last_word)) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= wrap_add(g_reg, 1);
          end else if (xfer) begin
            bcnt_reg <= bcnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({xfer, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Two-entry output buffer: head_reg is the visible word, tail_reg the
  // second one. xfer at count 2 implies pop, so the push never overflows.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      empty_reg <= 1'b1;
      err_reg   <= 1'b0;
    end else begin
      if (xfer) begin
        if (count_reg == 2'd0 || (count_reg == 2'd1 && pop)) begin
          head_reg <= src_word[g_reg];
        end else if (count_reg == 2'd1) begin
          tail_reg <= src_word[g_reg];
        end else begin
          head_reg <= tail_reg;
          tail_reg <= src_word[g_reg];
        end
      end else if (pop) begin
        head_reg <= tail_reg;
      end
      count_reg <= count_next;
      empty_reg <= (count_next == 2'd0);
      if (bus.OUT_READ && empty_reg) err_reg <= 1'b1;
    end
  end

  assign bus.OUT_EMPTY  = empty_reg;
  assign bus.OUT_DATA   = head_reg;
  assign bus.GRANT      = grant_reg;
  assign bus.READ_ERROR = err_reg;

endmodule

// File: tb/tb_fifo_merge_rr.sv
// ---------------------------------------------------------------------------
// tb_fifo_merge_rr
// Bench for fifo_merge_rr (N_SRC=5, DSIZE=32, MAX_BURST=4). Sources are
// modelled as word queues presented FWFT; the expected output stream and
// grant sequence are derived from the round-robin burst rules applied to the
// queue contents loaded before each drain.
// ---------------------------------------------------------------------------
module tb_fifo_merge_rr;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  fifo_merge_rr_if #(.N_SRC(N), .DSIZE(DW)) bus ();

  fifo_merge_rr #(.N_SRC(N), .DSIZE(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK (clk),
    .BUS_RST (srst),
    .bus     (bus)
  );

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [DW-1:0] srcq [N][$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            run_q[$];
  int            gap_q[$];
  int            exp_runs[$];
  int            ptr_m;
  int            bad_reads;
  int            read_cycles;
  int            zero_len;
  logic [N-1:0]  last_grant;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.SRC_EMPTY[i] = (srcq[i].size() == 0);
      bus.SRC_DATA[i*DW +: DW] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_records();
    got_q.delete(); run_q.delete(); gap_q.delete();
    bad_reads = 0; read_cycles = 0; zero_len = 0; last_grant = '0;
  endtask

  // One clock: observe at the falling edge, apply source pops and refresh
  // the source view 1 time unit after the rising edge.
  task automatic tick();
    logic [N-1:0] rd;
    int gidx;
    @(negedge clk);
    rd = bus.SRC_READ;
    if (bus.OUT_READ && !bus.OUT_EMPTY) begin
      got_q.push_back(bus.OUT_DATA);
      $display("[TB] t=%0t pop word 0x%08h grant %b", $time, bus.OUT_DATA, bus.GRANT);
    end
    if (rd != '0) read_cycles++;
    if ($countones(rd) > 1 || (rd & ~bus.GRANT) != '0) bad_reads++;
    if (bus.GRANT != '0 && !$onehot(bus.GRANT)) bad_reads++;
    if (bus.GRANT == '0) begin
      zero_len++;
    end else if (bus.GRANT != last_grant) begin
      gidx = 0;
      for (int i = 0; i < N; i++) if (bus.GRANT[i]) gidx = i;
      if (run_q.size() > 0) gap_q.push_back(zero_len);
      run_q.push_back(gidx);
      zero_len = 0;
    end
    last_grant = bus.GRANT;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        if (srcq[i].size() == 0) bad_reads++;
        else void'(srcq[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    bus.OUT_READ = 1'b0;
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    ptr_m = 0;
    clear_records();
  endtask

  task automatic load(input int s, input int n);
    for (int j = 0; j < n; j++) srcq[s].push_back({s[3:0], j[3:0], 24'($urandom)});
    drive();
  endtask

  // Reference: walk sources in round-robin order from ptr_m, each grant
  // taking min(remaining, MB) words, search restarting after the source.
  task automatic build_expected();
    int rem [N];
    int idx [N];
    int p, s, n;
    exp_q.delete();
    exp_runs.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = srcq[i].size();
      idx[i] = 0;
    end
    p = ptr_m;
    for (int guard = 0; guard < 1000; guard++) begin
      s = -1;
      for (int k = 0; k < N; k++) if (s < 0 && rem[(p + k) % N] > 0) s = (p + k) % N;
      if (s < 0) break;
      n = (rem[s] < MB) ? rem[s] : MB;
      for (int j = 0; j < n; j++) exp_q.push_back(srcq[s][idx[s] + j]);
      idx[s] += n;
      rem[s] -= n;
      exp_runs.push_back(s);
      p = (s + 1) % N;
    end
    ptr_m = p;
  endtask

  task automatic drain(input int pct, output bit timed_out);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    timed_out = 1'b0;
    while (!done) begin
      bus.OUT_READ = ($urandom_range(0, 99) < pct);
      tick();
      cyc++;
      done = (got_q.size() >= exp_q.size()) && (bus.GRANT == '0) && all_empty();
      if (cyc >= 3000) begin
        timed_out = 1'b1;
        done = 1'b1;
      end
    end
    // A few extra reads expose any surplus or duplicated word.
    bus.OUT_READ = 1'b1;
    repeat (3) tick();
    bus.OUT_READ = 1'b0;
  endtask

  function automatic int stream_diffs();
    int d = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) d++;
    if (got_q.size() > exp_q.size()) d += got_q.size() - exp_q.size();
    return d;
  endfunction

  function automatic int run_diffs();
    int d = 0;
    for (int i = 0; i < exp_runs.size(); i++)
      if (i >= run_q.size() || run_q[i] != exp_runs[i]) d++;
    if (run_q.size() > exp_runs.size()) d += run_q.size() - exp_runs.size();
    return d;
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.OUT_EMPTY !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_out_empty: got %b required 1", bus.OUT_EMPTY);
    end
    tests_run++;
    if (bus.GRANT !== '0) begin
      fail_cnt++; $display("FAIL reset_grant: got %b required 00000", bus.GRANT);
    end
    tests_run++;
    if (bus.READ_ERROR !== 1'b0) begin
      fail_cnt++; $display("FAIL reset_read_error: got %b required 0", bus.READ_ERROR);
    end
    tests_run++;
    if (bus.OUT_DATA !== '0) begin
      fail_cnt++; $display("FAIL reset_out_data: got %h required 0", bus.OUT_DATA);
    end
    tests_run++;
    if (bus.SRC_READ !== '0) begin
      fail_cnt++; $display("FAIL reset_src_read: got %b required 00000", bus.SRC_READ);
    end
  endtask

  task automatic test_single();
    bit to;
    int d;
    do_reset();
    srcq[2].push_back(32'h0000_000A);
    srcq[2].push_back(32'h0000_000B);
    srcq[2].push_back(32'h0000_000C);
    drive();
    build_expected();
    bus.OUT_READ = 1'b1;
    tick();
    tests_run++;
    if (bus.GRANT !== 5'b00100 || bus.SRC_READ !== 5'b00100) begin
      fail_cnt++;
      $display("FAIL single_latency: grant %b src_read %b required 00100 00100", bus.GRANT, bus.SRC_READ);
    end
    tick();
    tests_run++;
    if (bus.OUT_EMPTY !== 1'b0 || bus.OUT_DATA !== 32'h0000_000A) begin
      fail_cnt++;
      $display("FAIL single_first_word: empty %b data %h required 0 0000000a", bus.OUT_EMPTY, bus.OUT_DATA);
    end
    drain(100, to);
    d = stream_diffs();
    tests_run++;
    if (to || d != 0) begin
      fail_cnt++;
      $display("FAIL single_stream: %0d words, %0d differ, timeout %0d, required %0d words", got_q.size(), d, to, exp_q.size());
    end
    tests_run++;
    if (read_cycles != 3) begin
      fail_cnt++; $display("FAIL single_read_cycles: got %0d required 3", read_cycles);
    end
    tests_run++;
    if (run_diffs() != 0 || bus.GRANT !== '0) begin
      fail_cnt++; $display("FAIL single_grant: %0d grants, final %b, required 1 grant to 2 then 0", run_q.size(), bus.GRANT);
    end
  endtask

  task automatic test_fairness();
    bit to;
    int d, badgap;
    do_reset();
    load(0, 10);
    load(1, 10);
    build_expected();
    drain(100, to);
    d = stream_diffs();
    tests_run++;
    if (to || d != 0) begin
      fail_cnt++;
      $display("FAIL fairness_stream: %0d words, %0d differ, timeout %0d, required %0d words", got_q.size(), d, to, exp_q.size());
    end
    tests_run++;
    if (run_diffs() != 0 || run_q.size() != 6) begin
      fail_cnt++; $display("FAIL fairness_grants: %0d grants (%0d differ) required 6 alternating", run_q.size(), run_diffs());
    end
    badgap = 0;
    foreach (gap_q[i]) if (gap_q[i] != 1) badgap++;
    tests_run++;
    if (badgap != 0 || gap_q.size() != 5) begin
      fail_cnt++; $display("FAIL fairness_idle_gap: %0d gaps, %0d not one cycle, required 5 gaps of 1", gap_q.size(), badgap);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    int d;
    do_reset();
    for (int s = 0; s < N; s++) load(s, 8);
    build_expected();
    drain(100, to);
    d = stream_diffs();
    tests_run++;
    if (to || d != 0) begin
      fail_cnt++;
      $display("FAIL rr_stream: %0d words, %0d differ, timeout %0d, required %0d words", got_q.size(), d, to, exp_q.size());
    end
    tests_run++;
    if (run_diffs() != 0) begin
      fail_cnt++; $display("FAIL rr_grant_order: %0d of %0d grants differ", run_diffs(), exp_runs.size());
    end
    tests_run++;
    if (run_q.size() < 6 || run_q[4] != 4 || run_q[5] != 0) begin
      fail_cnt++; $display("FAIL rr_wrap: %0d grants, required grant 4 followed by 0", run_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int d, stall_bad;
    logic [DW-1:0] held;
    do_reset();
    load(3, 8);
    build_expected();
    bus.OUT_READ = 1'b1;
    repeat (3) tick();
    bus.OUT_READ = 1'b0;
    stall_bad = 0;
    held = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) held = bus.OUT_DATA;
      if (k >= 2 && (bus.SRC_READ !== '0 || bus.OUT_EMPTY !== 1'b0 || bus.OUT_DATA !== held)) stall_bad++;
    end
    tests_run++;
    if (stall_bad != 0) begin
      fail_cnt++; $display("FAIL bp_stall: %0d stalled cycles with read/empty/data change, required 0", stall_bad);
    end
    drain(100, to);
    d = stream_diffs();
    tests_run++;
    if (to || d != 0) begin
      fail_cnt++;
      $display("FAIL bp_stream: %0d words, %0d differ, timeout %0d, required %0d words", got_q.size(), d, to, exp_q.size());
    end
    tests_run++;
    if (run_diffs() != 0 || bad_reads != 0) begin
      fail_cnt++; $display("FAIL bp_bursts: %0d grants, %0d bad reads, required 2 grants and 0", run_q.size(), bad_reads);
    end
  endtask

  task automatic test_read_error();
    do_reset();
    bus.OUT_READ = 1'b1;
    tick();
    tests_run++;
    if (bus.READ_ERROR !== 1'b1 || bus.OUT_EMPTY !== 1'b1) begin
      fail_cnt++; $display("FAIL read_error_set: err %b empty %b required 1 1", bus.READ_ERROR, bus.OUT_EMPTY);
    end
    bus.OUT_READ = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (bus.READ_ERROR !== 1'b1) begin
      fail_cnt++; $display("FAIL read_error_sticky: got %b required 1", bus.READ_ERROR);
    end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tests_run++;
    if (bus.READ_ERROR !== 1'b0) begin
      fail_cnt++; $display("FAIL read_error_clear: got %b required 0", bus.READ_ERROR);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    int cyc, d;
    do_reset();
    load(0, 2);
    load(3, 5);
    bus.OUT_READ = 1'b1;
    cyc = 0;
    while (srcq[3].size() > 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (srcq[3].size() != 3) begin
      fail_cnt++; $display("FAIL mid_reset_reach: src3 holds %0d words required 3", srcq[3].size());
    end
    srst = 1'b1;
    bus.OUT_READ = 1'b0;
    #1;
    tests_run++;
    if (bus.SRC_READ !== '0) begin
      fail_cnt++; $display("FAIL mid_reset_src_read: got %b required 00000", bus.SRC_READ);
    end
    tick();
    srst = 1'b0;
    tests_run++;
    if (bus.OUT_EMPTY !== 1'b1 || bus.GRANT !== '0) begin
      fail_cnt++; $display("FAIL mid_reset_state: empty %b grant %b required 1 00000", bus.OUT_EMPTY, bus.GRANT);
    end
    load(0, 3);
    ptr_m = 0;
    clear_records();
    build_expected();
    drain(100, to);
    tests_run++;
    if (run_q.size() == 0 || run_q[0] != 0) begin
      fail_cnt++; $display("FAIL mid_reset_restart: first grant %0d required 0", (run_q.size() > 0) ? run_q[0] : -1);
    end
    d = stream_diffs();
    tests_run++;
    if (to || d != 0) begin
      fail_cnt++;
      $display("FAIL mid_reset_stream: %0d words, %0d differ, timeout %0d, required %0d words", got_q.size(), d, to, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit to;
    int d, pct;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      clear_records();
      for (int s = 0; s < N; s++) load(s, $urandom_range(0, 9));
      if (all_empty()) load($urandom_range(0, N - 1), 1);
      build_expected();
      pct = $urandom_range(30, 100);
      drain(pct, to);
      d = stream_diffs();
      tests_run++;
      if (to || d != 0) begin
        fail_cnt++;
        $display("FAIL random_stream[%0d]: %0d words, %0d differ, timeout %0d, required %0d words", it, got_q.size(), d, to, exp_q.size());
      end
      tests_run++;
      if (run_diffs() != 0 || bad_reads != 0) begin
        fail_cnt++;
        $display("FAIL random_grants[%0d]: %0d grants (%0d differ), %0d bad reads, required %0d and 0", it, run_q.size(), run_diffs(), bad_reads, exp_runs.size());
      end
    end
  endtask

  initial begin
    srst = 1'b1;
    bus.OUT_READ = 1'b0;
    drive();
    test_reset();
    test_single();
    test_fairness();
    test_round_robin();
    test_backpressure();
    test_read_error();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
